hls_fp16_to_fp32_chn_o_wait_ctrl: RTL

Output-channel wait controller and holding buffer for the fp16-to-fp32 core; it is the transmit end of the valid/ready channel protocol.
- Accepts result words from the core under the core's wait-state signalling (iswt0 / core_wten / pending-write register).
- Buffers accepted words in a small FIFO.
- Presents them downstream on chn_o with a registered valid/ready handshake.
- Sits between the core datapath and the chn_o output port of the HLS top.

---
 rtl/hls_fp16_to_fp32_chn_o_wait_ctrl.sv | 99 +++++++++
 1 files changed

// File: rtl/hls_fp16_to_fp32_chn_o_wait_ctrl.sv
// Output-channel wait controller and holding FIFO for the fp16-to-fp32 core (chn_o transmit end).
// Optional backpressure stall counter enabled by HLS_FP16_TO_FP32_CHN_O_STALL_CNT_EN.
module hls_fp16_to_fp32_chn_o_wait_ctrl #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              nvdla_core_clk,
  input  logic              nvdla_core_rstn,
  input  logic              chn_o_rsci_iswt0,
  input  logic              core_wten,
  input  logic              core_wen,
  input  logic              chn_o_rsci_oswt,
  input  logic              chn_o_rsci_ld_core_psct,
  input  logic [DATA_W-1:0] chn_o_rsci_d,
  output logic              chn_o_rsci_bawt,
  output logic              chn_o_rsci_bdwt,
  output logic              chn_o_rsci_ld_core_sct,
  output logic              chn_o_vld,
  output logic [DATA_W-1:0] chn_o_data,
  input  logic              chn_o_rdy,
  output logic [CNT_W-1:0]  chn_o_stall_cnt
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = $clog2(DEPTH + 1);
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

  logic              icwt_q, icwt_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]  count_q, count_d;
  logic              vld_q, vld_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic pdswt0, ogwt, full, push, pop;

  // full comes from the registered count, so a same-cycle pop never frees room for a push
  always_comb begin
    pdswt0   = chn_o_rsci_iswt0 & ~core_wten;
    ogwt     = pdswt0 | icwt_q;
    full     = (count_q == OCC_FULL);
    push     = ogwt & ~full;
    pop      = vld_q & chn_o_rdy;
    icwt_d   = ogwt & ~push;
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    vld_d    = (count_d != '0);
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      icwt_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      vld_q    <= 1'b0;
    end else begin
      icwt_q   <= icwt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      vld_q    <= vld_d;
    end
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (push) mem_q[wr_ptr_q] <= chn_o_rsci_d;
  end

  assign chn_o_rsci_bawt        = push;
  assign chn_o_rsci_bdwt        = chn_o_rsci_oswt & core_wen;
  assign chn_o_rsci_ld_core_sct = chn_o_rsci_ld_core_psct & ogwt;
  assign chn_o_vld              = vld_q;
  assign chn_o_data             = mem_q[rd_ptr_q];

`ifdef HLS_FP16_TO_FP32_CHN_O_STALL_CNT_EN
  logic [CNT_W-1:0] stall_q;

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      stall_q <= '0;
    end else if (vld_q && !chn_o_rdy && (stall_q != '1)) begin
      stall_q <= stall_q + 1'b1;
    end
  end

  assign chn_o_stall_cnt = stall_q;
`else
  assign chn_o_stall_cnt = '0;
`endif

endmodule
